// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types: controller state and stage count
package rv32i_types;

   localparam int PIPE_NSTAGE = 5;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } pipe_state_t;

endpackage

// File: rtl/pipe_perf_counter.sv
// rtl/pipe_perf_counter.sv - wrapping event counter, cleared by synchronous reset
module pipe_perf_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc)
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - 5-stage freeze/stall/flush controller; PIPE_PERF_EN adds perf counters
module pipeline_controller
   import rv32i_types::*;
`ifdef PIPE_PERF_EN
#(
   parameter int PERF_W = 32
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic imem_resp,
   input  logic dmem_resp,
   input  logic mem_is_mem,
   input  logic hazard_stall_n,
   input  logic regwr_hazard_n,
   input  logic br_taken,
   output logic imem_read,
   output logic dmem_req,
   output logic load_pc,
   output logic load_if_id,
   output logic load_id_ex,
   output logic load_ex_mem,
   output logic load_mem_wb,
   output logic bubble_if_id,
   output logic bubble_id_ex
`ifdef PIPE_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
`endif
);

   pipe_state_t state;
   logic i_done_q, d_done_q;
   logic i_done, d_done, mem_ready;
   logic normal_adv, flush_adv;
   logic [PIPE_NSTAGE-1:0] loads;
   logic [1:0] bubbles;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
      end else if (mem_ready) begin
         state    <= RUN;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
      end else begin
         state    <= WAIT;
         i_done_q <= i_done | imem_resp;
         d_done_q <= d_done | (dmem_resp & mem_is_mem);
      end
   end

   // Sticky bits only carry meaning while frozen; RUN always starts a fresh fetch.
   always_comb begin
      i_done     = (state == WAIT) && i_done_q;
      d_done     = (state == WAIT) && d_done_q;
      mem_ready  = (imem_resp | i_done) & (~mem_is_mem | dmem_resp | d_done);
      loads      = '0;
      bubbles    = 2'b00;
      normal_adv = 1'b0;
      flush_adv  = 1'b0;
      if (!rst && mem_ready) begin
         if (br_taken) begin
            loads     = '1;
            bubbles   = 2'b11;
            flush_adv = 1'b1;
         end else if (!hazard_stall_n) begin
            loads   = 5'b00111;
            bubbles = 2'b01;
         end else if (!regwr_hazard_n) begin
            loads   = 5'b01111;
            bubbles = 2'b10;
         end else begin
            loads      = '1;
            normal_adv = 1'b1;
         end
      end
   end

   assign imem_read    = ~rst & ~i_done;
   assign dmem_req     = ~rst & mem_is_mem & ~d_done;
   assign load_pc      = loads[4];
   assign load_if_id   = loads[3];
   assign load_id_ex   = loads[2];
   assign load_ex_mem  = loads[1];
   assign load_mem_wb  = loads[0];
   assign bubble_if_id = bubbles[1];
   assign bubble_id_ex = bubbles[0];

`ifdef PIPE_PERF_EN
   pipe_perf_counter #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (~rst & ~normal_adv),
      .count (stall_cycles)
   );

   pipe_perf_counter #(.W(PERF_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_adv),
      .count (flush_count)
   );
`else
   logic unused_perf;
   assign unused_perf = normal_adv ^ flush_adv;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed scenarios plus randomized run against a behavioural model
module tb_pipeline_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic imem_resp = 1'b0, dmem_resp = 1'b0, mem_is_mem = 1'b0;
   logic hazard_stall_n = 1'b1, regwr_hazard_n = 1'b1, br_taken = 1'b0;
   logic imem_read, dmem_req;
   logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic bubble_if_id, bubble_id_ex;
`ifdef PIPE_PERF_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_controller dut (
      .clk            (clk),
      .rst            (rst),
      .imem_resp      (imem_resp),
      .dmem_resp      (dmem_resp),
      .mem_is_mem     (mem_is_mem),
      .hazard_stall_n (hazard_stall_n),
      .regwr_hazard_n (regwr_hazard_n),
      .br_taken       (br_taken),
      .imem_read      (imem_read),
      .dmem_req       (dmem_req),
      .load_pc        (load_pc),
      .load_if_id     (load_if_id),
      .load_id_ex     (load_id_ex),
      .load_ex_mem    (load_ex_mem),
      .load_mem_wb    (load_mem_wb),
      .bubble_if_id   (bubble_if_id),
      .bubble_id_ex   (bubble_id_ex)
`ifdef PIPE_PERF_EN
      ,
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] dut_vec();
      return {imem_read, dmem_req, load_pc, load_if_id, load_id_ex, load_ex_mem,
              load_mem_wb, bubble_if_id, bubble_id_ex};
   endfunction

   // Model: has this instruction bundle's fetch / data access already been answered?
   bit got_fetch = 0, got_data = 0;
   int unsigned m_stall = 0, m_flush = 0;

   always @(negedge clk) begin
      logic [8:0] exp;
      bit fetch_ok, data_ok, ready, normal;
      fetch_ok = got_fetch || imem_resp;
      data_ok  = !mem_is_mem || got_data || dmem_resp;
      ready    = fetch_ok && data_ok;
      normal   = 0;
      if (rst) exp = '0;
      else begin
         exp[8] = !got_fetch;
         exp[7] = mem_is_mem && !got_data;
         if (!ready)               exp[6:0] = 7'b00000_00;
         else if (br_taken)        exp[6:0] = 7'b11111_11;
         else if (!hazard_stall_n) exp[6:0] = 7'b00111_01;
         else if (!regwr_hazard_n) exp[6:0] = 7'b01111_10;
         else begin
            exp[6:0] = 7'b11111_00;
            normal = 1;
         end
      end
      chk("ctrl_vec", {55'd0, dut_vec()}, {55'd0, exp});
`ifdef PIPE_PERF_EN
      chk("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
      chk("flush_count", {32'd0, flush_count}, {32'd0, m_flush});
`endif
      if (rst) begin
         got_fetch = 0; got_data = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!normal) m_stall++;
         if (ready && br_taken) m_flush++;
         if (ready) begin
            got_fetch = 0; got_data = 0;
         end else begin
            got_fetch = fetch_ok;
            got_data  = got_data || (mem_is_mem && dmem_resp);
         end
      end
   end

   task automatic cyc(input logic r, ir, dr, mm, hs, rw, br);
      @(posedge clk);
      #1;
      rst = r; imem_resp = ir; dmem_resp = dr; mem_is_mem = mm;
      hazard_stall_n = hs; regwr_hazard_n = rw; br_taken = br;
      @(negedge clk);
      #1;
   endtask

   initial begin
      // reset
      @(negedge clk);
      #1;
      chk("reset_outputs", {55'd0, dut_vec()}, 64'd0);
      cyc(1, 1, 1, 1, 1, 1, 1);
      chk("reset_outputs_busy_inputs", {55'd0, dut_vec()}, 64'd0);

      // steady fetch, no hazards
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 0, 0, 1, 1, 0);
         chk("steady_advance", {55'd0, dut_vec()}, 64'b1_0_11111_00);
      end
`ifdef PIPE_PERF_EN
      cyc(0, 1, 0, 0, 1, 1, 0);
      chk("steady_no_stall", {32'd0, stall_cycles}, 64'd0);
`endif

      // fetch answers at +1, data at +3
      cyc(0, 0, 0, 1, 1, 1, 0);
      chk("mem_freeze0", {55'd0, dut_vec()}, 64'b1_1_00000_00);
      cyc(0, 1, 0, 1, 1, 1, 0);
      chk("mem_freeze1", {55'd0, dut_vec()}, 64'b1_1_00000_00);
      cyc(0, 0, 0, 1, 1, 1, 0);
      chk("mem_freeze2_idone", {55'd0, dut_vec()}, 64'b0_1_00000_00);
      cyc(0, 0, 1, 1, 1, 1, 0);
      chk("mem_release", {55'd0, dut_vec()}, 64'b0_1_11111_00);
      cyc(0, 1, 0, 0, 1, 1, 0);
      chk("after_release", {55'd0, dut_vec()}, 64'b1_0_11111_00);
`ifdef PIPE_PERF_EN
      chk("mem_stall_count", {32'd0, stall_cycles}, 64'd3);
`endif

      // load-use stall, then normal
      cyc(0, 1, 0, 0, 0, 1, 0);
      chk("load_use", {55'd0, dut_vec()}, 64'b1_0_00111_01);
      cyc(0, 1, 0, 0, 1, 1, 0);
      chk("load_use_next", {55'd0, dut_vec()}, 64'b1_0_11111_00);

      // both hazards, then regfile hazard alone
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("both_hazards", {55'd0, dut_vec()}, 64'b1_0_00111_01);
      cyc(0, 1, 0, 0, 1, 0, 0);
      chk("regwr_hazard", {55'd0, dut_vec()}, 64'b1_0_01111_10);

      // branch held across a 2-cycle data freeze
      cyc(0, 1, 0, 1, 0, 1, 1);
      chk("br_freeze0", {55'd0, dut_vec()}, 64'b1_1_00000_00);
      cyc(0, 0, 0, 1, 0, 1, 1);
      chk("br_freeze1", {55'd0, dut_vec()}, 64'b0_1_00000_00);
      cyc(0, 0, 1, 1, 0, 1, 1);
      chk("br_release", {55'd0, dut_vec()}, 64'b0_1_11111_11);
      cyc(0, 1, 0, 0, 1, 1, 0);
      chk("br_after", {55'd0, dut_vec()}, 64'b1_0_11111_00);
`ifdef PIPE_PERF_EN
      chk("flush_once", {32'd0, flush_count}, 64'd1);
`endif

      // reset mid-WAIT with a recorded fetch response
      cyc(0, 1, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 1, 0);
      chk("wait_before_rst", {55'd0, dut_vec()}, 64'b0_1_00000_00);
      cyc(1, 0, 0, 1, 1, 1, 0);
      chk("rst_mid_wait", {55'd0, dut_vec()}, 64'd0);
      cyc(0, 0, 0, 0, 1, 1, 0);
      chk("fresh_fetch", {55'd0, dut_vec()}, 64'b1_0_00000_00);
`ifdef PIPE_PERF_EN
      chk("rst_stall_zero", {32'd0, stall_cycles}, 64'd0);
      chk("rst_flush_zero", {32'd0, flush_count}, 64'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 40,
             $urandom_range(0, 99) < 50,
             $urandom_range(0, 99) >= 20,
             $urandom_range(0, 99) >= 20,
             $urandom_range(0, 99) < 15);
      end

      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter PERF_W, default 32, sets the width of the performance counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_resp  input  1  instruction memory response; fetch data valid this cycle.
REQ-005 dmem_resp  input  1  data memory response; load data valid or store done this cycle.
REQ-006 mem_is_mem  input  1  MEM stage holds a valid load or store.
REQ-007 hazard_stall_n  input  1  active-low load-use stall from the hazard unit (EX load feeds ID).
REQ-008 regwr_hazard_n  input  1  active-low regfile-write hazard from the hazard unit (MEM write feeds IF).
REQ-009 br_taken  input  1  EX stage resolved taken branch or jump.
REQ-010 imem_read  output  1  instruction fetch request.
REQ-011 dmem_req  output  1  data memory request.
REQ-012 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  stage register load enables.
REQ-013 bubble_if_id, bubble_id_ex  output  1 each  stage register loads a NOP (valid=0) instead of upstream data.
REQ-014 stall_cycles, flush_count  output  PERF_W each  perf counters; present only with PIPE_PERF_EN.

Function
REQ-015 FSM states are RUN and WAIT.
REQ-016 Sticky bits i_done and d_done record responses that arrive while the other request is still outstanding.
REQ-017 imem_read is 1 in every non-reset cycle until imem_resp or i_done.
REQ-018 dmem_req is 1 while mem_is_mem=1 and neither dmem_resp nor d_done has occurred.
REQ-019 Memory-ready condition: (imem_resp|i_done) & (!mem_is_mem|dmem_resp|d_done).
REQ-020 RUN->WAIT when memory-ready=0; WAIT->RUN in the cycle memory-ready=1.
REQ-021 When memory-ready=0, all load_* and bubble_* are 0 (global freeze), and arriving responses set the matching sticky bit.
REQ-022 In the cycle memory-ready=1, the pipeline advances under REQ-023..REQ-026 and both sticky bits clear.
REQ-023 Advance priority is br_taken > hazard_stall_n=0 > regwr_hazard_n=0 > normal.
REQ-024 br_taken: all load_* are 1, and bubble_if_id=1 and bubble_id_ex=1; hazard inputs are ignored that cycle.
REQ-025 hazard_stall_n=0: load_pc=0, load_if_id=0, load_id_ex=1 with bubble_id_ex=1, load_ex_mem=1, load_mem_wb=1.
REQ-026 regwr_hazard_n=0 (hazard_stall_n=1): load_pc=0, load_if_id=1 with bubble_if_id=1, all others 1.
REQ-027 Normal advance: all load_* are 1 and all bubble_* are 0.
REQ-028 If both hazards are asserted together, REQ-025 applies.
REQ-029 A br_taken held across a freeze takes effect exactly once, in the release cycle.
REQ-030 Control outputs are combinational from state plus inputs, with zero-cycle latency.

Reset
REQ-031 While rst=1: state=RUN, i_done=0, d_done=0, all load_* and bubble_* are 0, imem_read=0, dmem_req=0, perf counters are 0.
REQ-032 Reset asserted mid-WAIT abandons the outstanding requests; the first cycle after reset is RUN with a fresh fetch.

Configuration
REQ-033 With PIPE_PERF_EN defined, stall_cycles increments for every cycle that is not a normal advance (freeze, hazard or flush).
REQ-034 With PIPE_PERF_EN defined, flush_count increments on every applied br_taken; both counters wrap modulo 2^PERF_W.
REQ-035 Without PIPE_PERF_EN, the counter ports and logic are absent and all other behaviour is identical.

Structure
REQ-036 A pipe_state_t enum {RUN, WAIT} and a PIPE_NSTAGE=5 constant live in the shared rv32i_types package.
REQ-037 One sub-module, pipe_perf_counter (a saturating-free wrapping counter), is instantiated twice under PIPE_PERF_EN.

Verification
REQ-038 Scenario: imem_resp=1 every cycle, no hazards, 10 cycles -> all load_*=1 every cycle, state stays RUN, stall_cycles=0.
REQ-039 Scenario: mem_is_mem=1, dmem_resp at cycle+3, imem_resp at cycle+1 -> 3 freeze cycles, i_done=1 from cycle+2, advance at cycle+3, stall_cycles=3.
REQ-040 Scenario: hazard_stall_n=0 for 1 cycle -> load_pc=0, load_if_id=0, bubble_id_ex=1; next cycle normal.
REQ-041 Scenario: regwr_hazard_n=0 with hazard_stall_n=0 -> REQ-025 outputs; with hazard_stall_n=1 -> bubble_if_id=1, load_pc=0.
REQ-042 Scenario: br_taken=1 during a 2-cycle dmem freeze -> no loads for 2 cycles, then a single release cycle with both bubbles=1 and flush_count=1.
REQ-043 Scenario: rst pulsed mid-WAIT -> all outputs 0 during reset; the next cycle is RUN with imem_read=1 and counters 0.
